// File: rtl/ps2_event_rx.sv
`timescale 1ns/1ps
// Event queue for decoded PS/2 key events; first-word-fall-through, head reads 0 when empty.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: pop only while ready; a push into a full queue is dropped and flagged unless a pop frees a slot.
module ps2_event_fifo #(
    parameter int W  = 10,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop_rdy,
    output logic          head_vld,
    output logic [W-1:0]  head_dat,
    output logic [AW:0]   level,
    output logic          overflow
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic          empty, full, do_pop, do_push;

    always_comb begin
        empty    = (cnt_q == '0);
        full     = (cnt_q == (AW+1)'(DEPTH));
        do_pop   = pop_rdy & ~empty;
        do_push  = push_vld & (~full | do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        ovf_d = push_vld & ~do_push;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    assign head_vld = ~empty;
    assign head_dat = empty ? '0 : mem_q[rd_ptr_q];
    assign level    = cnt_q;
    assign overflow = ovf_q;
endmodule

// PS/2 device-to-host receiver: filters the lines, frames bytes, folds E0/F0 prefixes into key events.
// Latency: event pushed 1 cycle after the stop-bit fall strobe, ev_valid one cycle later.
// Backpressure: events queue until ev_ready; when the queue is full new events are dropped with overflow.
module ps2_event_rx #(
    parameter int CLK_HZ     = 50000000,
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT_US = 2000,
    parameter int FIFO_AW    = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic [7:0]         ev_code,
    output logic               ev_extended,
    output logic               ev_break,
    output logic [FIFO_AW:0]   fifo_level,
    output logic               overflow,
    output logic               parity_err,
    output logic               frame_err
);
    localparam logic [31:0] TO_CYC    = 32'(CLK_HZ / 1000000 * TIMEOUT_US);
    localparam logic [7:0]  FILT_LAST = 8'(FILTER_LEN - 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Index 1 carries the clock line, index 0 the data line.
    logic [1:0]  sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d;
    logic [7:0]  fcnt_q [2];
    logic [7:0]  fcnt_d [2];
    logic [1:0]  vld_sh_q, vld_sh_d;
    logic        armed_q, armed_d, fall_q, fall_d;
    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d, byte_q, byte_d;
    logic        par_q, par_d, done_q, done_d, perr_q, perr_d, ferr_q, ferr_d;
    logic [31:0] to_cnt_q, to_cnt_d;
    logic        ext_q, ext_d, brk_q, brk_d, push;

    always_comb begin
        sync1_d  = {ps2_clk, ps2_data};
        sync2_d  = sync1_q;
        vld_sh_d = {vld_sh_q[0], 1'b1};
        filt_d   = filt_q;
        fcnt_d   = '{default: '0};
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FILT_LAST) filt_d[i] = sync2_q[i];
                else                        fcnt_d[i] = fcnt_q[i] + 8'd1;
            end
        end
        // Edges count only once a genuinely synchronised high clock has been observed.
        armed_d = armed_q | (vld_sh_q[1] & sync2_q[1] & filt_q[1]);
        fall_d  = armed_q & filt_q[1] & ~filt_d[1];
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        byte_d    = byte_q;
        done_d    = 1'b0;
        perr_d    = 1'b0;
        ferr_d    = 1'b0;
        to_cnt_d  = (state_q == IDLE || fall_q) ? '0 : to_cnt_q + 32'd1;
        if (fall_q) begin
            unique case (state_q)
                IDLE: begin
                    if (!filt_q[0]) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end
                end
                DATA: begin
                    shift_d   = {filt_q[0], shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = filt_q[0];
                    state_d = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (!(^{shift_q, par_q})) begin
                        perr_d = 1'b1;
                    end else if (!filt_q[0]) begin
                        ferr_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        byte_d = shift_q;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && to_cnt_q == TO_CYC) begin
            state_d = IDLE;
            ferr_d  = 1'b1;
        end
    end

    // Prefix folding: E0/F0 only arm flags; any discarded frame forgets a pending prefix.
    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        push  = 1'b0;
        if (perr_q || ferr_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (done_q) begin
            if (byte_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_d = 1'b1;
            end else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q   <= 2'b11;
            sync2_q   <= 2'b11;
            filt_q    <= 2'b11;
            fcnt_q    <= '{default: '0};
            vld_sh_q  <= '0;
            armed_q   <= 1'b0;
            fall_q    <= 1'b0;
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            byte_q    <= '0;
            done_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            to_cnt_q  <= '0;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            filt_q    <= filt_d;
            fcnt_q    <= fcnt_d;
            vld_sh_q  <= vld_sh_d;
            armed_q   <= armed_d;
            fall_q    <= fall_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            byte_q    <= byte_d;
            done_q    <= done_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            to_cnt_q  <= to_cnt_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
        end
    end

    ps2_event_fifo #(.W(10), .AW(FIFO_AW)) u_fifo (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .push_vld (push),
        .push_dat ({brk_q, ext_q, byte_q}),
        .pop_rdy  (ev_ready),
        .head_vld (ev_valid),
        .head_dat ({ev_break, ev_extended, ev_code}),
        .level    (fifo_level),
        .overflow (overflow)
    );

    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
endmodule

// File: tb/tb_ps2_event_rx.sv
`timescale 1ns/1ps
// Directed bench for ps2_event_rx: drives PS/2 frames, records popped events and error pulses on the falling edge.
module tb_ps2_event_rx;
    localparam int FL   = 8;
    localparam int AW   = 4;
    localparam int HALF = 20;

    logic        sys_clk = 1'b0, sys_rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, ev_ready = 1'b0;
    logic        ev_valid, ev_extended, ev_break, overflow, parity_err, frame_err;
    logic [7:0]  ev_code;
    logic [AW:0] fifo_level;

    ps2_event_rx #(.CLK_HZ(1000000), .FILTER_LEN(FL), .TIMEOUT_US(300), .FIFO_AW(AW)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_extended(ev_extended),
        .ev_break(ev_break), .fifo_level(fifo_level), .overflow(overflow),
        .parity_err(parity_err), .frame_err(frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    int n_vec = 0, n_bad = 0;
    int perr_n = 0, ferr_n = 0, ovf_n = 0, vld_cyc = 0;
    logic [9:0] evq [$];

    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            if (ev_valid && ev_ready) evq.push_back({ev_break, ev_extended, ev_code});
            if (ev_valid)   vld_cyc++;
            if (parity_err) perr_n++;
            if (frame_err)  ferr_n++;
            if (overflow)   ovf_n++;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_ev(input string tag, input int idx, input int exp);
        if (idx < evq.size()) chk(tag, int'(evq[idx]), exp);
        else                  chk(tag, -1, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    // One PS/2 bit; a glitch shorter than the filter is injected into each half when requested.
    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            tick(5); ps2_clk = 1'b0; tick(FL - 1); ps2_clk = 1'b1; tick(HALF - 5 - (FL - 1));
        end else begin
            tick(HALF);
        end
        ps2_clk = 1'b0;
        if (glitch) begin
            tick(5); ps2_clk = 1'b1; tick(FL - 1); ps2_clk = 1'b0; tick(HALF - 5 - (FL - 1));
        end else begin
            tick(HALF);
        end
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop_b, input int gbit);
        logic        p;
        logic [10:0] f;
        p = ~(^b);
        p = p ^ bad_par;
        f = {stop_b, p, b, 1'b0};
        for (int i = 0; i < 11; i++) ps2_bit(f[i], i == gbit);
        ps2_data = 1'b1;
        tick(60);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p0, f0, o0, v0;
        #23;
        chk("rst_valid", ev_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_code", ev_code, 0);
        chk("rst_pulses", {overflow, parity_err, frame_err, ev_break, ev_extended}, 0);
        sys_rst_n = 1'b1;
        tick(20);

        // Single plain key
        ev_ready = 1'b1;
        evq.delete();
        v0 = vld_cyc;
        send_frame(8'h1C, 0, 1, -1);
        chk("t1_count", evq.size(), 1);
        chk_ev("t1_event", 0, 10'h01C);
        chk("t1_valid_cycles", vld_cyc - v0, 1);
        chk("t1_level", fifo_level, 0);

        // Prefix folding
        evq.delete();
        send_frame(8'hF0, 0, 1, -1);
        send_frame(8'h1C, 0, 1, -1);
        send_frame(8'hE0, 0, 1, -1);
        send_frame(8'hF0, 0, 1, -1);
        send_frame(8'h75, 0, 1, -1);
        chk("t2_count", evq.size(), 2);
        chk_ev("t2_break", 0, 10'h21C);
        chk_ev("t2_ext_break", 1, 10'h375);

        // Bad parity, then bad stop bit clearing a pending E0
        p0 = perr_n; f0 = ferr_n;
        evq.delete();
        send_frame(8'h1C, 1, 1, -1);
        send_frame(8'h32, 0, 1, -1);
        chk("t3_parity_pulses", perr_n - p0, 1);
        chk("t3_count", evq.size(), 1);
        chk_ev("t3_event", 0, 10'h032);
        evq.delete();
        send_frame(8'hE0, 0, 1, -1);
        send_frame(8'h55, 0, 0, -1);
        send_frame(8'h74, 0, 1, -1);
        chk("t3_frame_pulses", ferr_n - f0, 1);
        chk("t3_parity_total", perr_n - p0, 1);
        chk_ev("t3_ext_cleared", 0, 10'h074);

        // Timeout after four data bits
        f0 = ferr_n;
        evq.delete();
        ps2_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1, 0);
        ps2_data = 1'b1;
        tick(400);
        chk("t4_timeout_pulses", ferr_n - f0, 1);
        chk("t4_no_event", evq.size(), 0);
        send_frame(8'h29, 0, 1, -1);
        chk("t4_count", evq.size(), 1);
        chk_ev("t4_event", 0, 10'h029);
        chk("t4_frame_total", ferr_n - f0, 1);

        // Fill beyond depth with consumer stalled
        ev_ready = 1'b0;
        o0 = ovf_n;
        evq.delete();
        for (int i = 1; i <= 17; i++) send_frame(8'(i), 0, 1, -1);
        chk("t5_level_full", fifo_level, 16);
        chk("t5_overflow", ovf_n - o0, 1);
        chk("t5_valid", ev_valid, 1);
        chk("t5_head", ev_code, 8'h01);
        ev_ready = 1'b1;
        tick(40);
        chk("t5_level_drained", fifo_level, 0);
        chk("t5_count", evq.size(), 16);
        for (int i = 0; i < 16; i++) chk_ev("t5_order", i, i + 1);

        // Sub-filter glitches on an idle line and inside frames
        p0 = perr_n; f0 = ferr_n;
        evq.delete();
        ps2_data = 1'b0;
        tick(20);
        ps2_clk = 1'b0; tick(FL - 1); ps2_clk = 1'b1;
        tick(20);
        ps2_data = 1'b1;
        tick(20);
        send_frame(8'h5A, 0, 1, 3);
        send_frame(8'h6B, 0, 1, 9);
        chk("t6_count", evq.size(), 2);
        chk_ev("t6_event0", 0, 10'h05A);
        chk_ev("t6_event1", 1, 10'h06B);
        chk("t6_errors", (perr_n - p0) + (ferr_n - f0), 0);

        // Asynchronous reset mid-frame with a queued event
        ev_ready = 1'b0;
        evq.delete();
        send_frame(8'h66, 0, 1, -1);
        chk("t7_pre_level", fifo_level, 1);
        ps2_bit(1'b0, 0);
        ps2_bit(1'b1, 0);
        ps2_bit(1'b0, 0);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", ev_valid, 0);
        chk("t7_rst_level", fifo_level, 0);
        chk("t7_rst_code", ev_code, 0);
        ps2_data = 1'b1;
        tick(3);
        sys_rst_n = 1'b1;
        tick(20);
        ev_ready = 1'b1;
        f0 = ferr_n;
        evq.delete();
        send_frame(8'h33, 0, 1, -1);
        chk("t7_count", evq.size(), 1);
        chk_ev("t7_event", 0, 10'h033);
        chk("t7_no_frame_err", ferr_n - f0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
